ppu_mem_responder: RTL and testbench

PPU_MEM_RESPONDER -- requirements
Module: ppu_mem_responder

---
 rtl/ppu_mem_responder.sv | 128 ++++++++++++
 tb/tb_ppu_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_mem_responder.sv
// PPU memory responder: dual-port VRAM/OAM with CPU and PPU read ports plus an OAM DMA engine.
// Define PPU_MEM_LOCKOUT_EN to block CPU VRAM/OAM access while the PPU owns the memory.
module ppu_mem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_en,
  output logic [15:0] dma_src_addr,
  output logic        dma_src_rd,
  input  logic [7:0]  dma_src_data,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t     state, state_nxt;
  logic [7:0] dma_reg;
  logic [7:0] idx;

  logic [7:0] vram [0:8191];
  logic [7:0] oam  [0:159];

  logic cpu_vram, cpu_oam, cpu_dma, ppu_vram, ppu_oam;
  logic lock_vram, lock_oam;
  logic cpu_vram_ok, cpu_oam_ok;
  logic dma_start, dma_wr, vram_we, cpu_oam_we;
  logic [7:0] cpu_rd_val, ppu_rd_val;

  assign cpu_vram = cpu_addr[15:13] == 3'b100;
  assign cpu_oam  = cpu_addr[15:8] == 8'hFE && cpu_addr[7:0] < 8'd160;
  assign cpu_dma  = cpu_addr == 16'hFF46;
  assign ppu_vram = ppu_addr[15:13] == 3'b100;
  assign ppu_oam  = ppu_addr[15:8] == 8'hFE && ppu_addr[7:0] < 8'd160;

`ifdef PPU_MEM_LOCKOUT_EN
  assign lock_vram = lcd_en && ppu_mode == 2'd3;
  assign lock_oam  = lcd_en && ppu_mode[1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{lcd_en, ppu_mode};
  assign lock_vram  = 1'b0;
  assign lock_oam   = 1'b0;
`endif

  assign cpu_vram_ok = cpu_vram && !lock_vram;
  assign cpu_oam_ok  = cpu_oam && !lock_oam && !dma_active;
  assign dma_start   = cpu_wr && cpu_dma;
  // A reset cycle must not commit the in-flight DMA byte.
  assign dma_wr      = state == WRITE && !rst;
  assign vram_we     = cpu_wr && cpu_vram_ok;
  assign cpu_oam_we  = cpu_wr && cpu_oam_ok && !dma_wr;

  // Storage has no reset; nonblocking writes give read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (vram_we) vram[cpu_addr[12:0]] <= cpu_wdata;
    if (dma_wr)
      oam[idx] <= dma_src_data;
    else if (cpu_oam_we)
      oam[cpu_addr[7:0]] <= cpu_wdata;
  end

  always_comb begin
    cpu_rd_val = 8'hFF;
    if (cpu_vram_ok)     cpu_rd_val = vram[cpu_addr[12:0]];
    else if (cpu_oam_ok) cpu_rd_val = oam[cpu_addr[7:0]];
    else if (cpu_dma)    cpu_rd_val = dma_reg;
  end

  always_comb begin
    ppu_rd_val = 8'hFF;
    if (ppu_vram)                   ppu_rd_val = vram[ppu_addr[12:0]];
    else if (ppu_oam && !dma_active) ppu_rd_val = oam[ppu_addr[7:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= 8'hFF;
      ppu_rdata <= 8'hFF;
    end else begin
      if (cpu_rd) cpu_rdata <= cpu_rd_val;
      if (ppu_rd) ppu_rdata <= ppu_rd_val;
    end
  end

  // DMA FSM: state register plus index/source datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 8'd0;
      dma_reg <= 8'd0;
    end else begin
      state <= state_nxt;
      if (dma_start) begin
        dma_reg <= cpu_wdata;
        idx     <= 8'd0;
      end else if (state == WRITE) begin
        idx <= (idx == 8'd159) ? 8'd0 : idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = IDLE;
      REQ:     state_nxt = WRITE;
      WRITE:   state_nxt = (idx == 8'd159) ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
    if (dma_start) state_nxt = REQ;
  end

  always_comb begin
    dma_active   = state != IDLE;
    dma_src_rd   = state == REQ;
    dma_src_addr = 16'h0000;
    if (state == REQ) dma_src_addr = {dma_reg, 8'h00} + {8'h00, idx};
  end

endmodule

// File: tb/tb_ppu_mem_responder.sv
// Self-checking bench for ppu_mem_responder: random CPU/PPU traffic against array models plus directed DMA scenarios.
module tb_ppu_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [1:0]  ppu_mode;
  logic        lcd_en;
  logic [15:0] dma_src_addr;
  logic        dma_src_rd;
  logic [7:0]  dma_src_data;
  logic        dma_active;

  always #5 clk = ~clk;

  ppu_mem_responder dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
    .ppu_rdata(ppu_rdata), .ppu_mode(ppu_mode), .lcd_en(lcd_en),
    .dma_src_addr(dma_src_addr), .dma_src_rd(dma_src_rd), .dma_src_data(dma_src_data),
    .dma_active(dma_active)
  );

`ifdef PPU_MEM_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  // System-bus source: data is a function of the address, returned one cycle after the strobe.
  bit src_xor = 1'b0;
  always @(posedge clk)
    dma_src_data <= dma_src_rd ? (dma_src_addr[7:0] ^ (src_xor ? dma_src_addr[15:8] : 8'h00)) : 8'h00;

  int n_chk = 0, n_fail = 0;
  logic [7:0] vram_m [0:8191];
  logic [7:0] oam_m  [0:159];
  logic [7:0] dma_m = 8'h00;

  function automatic bit is_vram(input logic [15:0] a); return a >= 16'h8000 && a < 16'hA000; endfunction
  function automatic bit is_oam(input logic [15:0] a);  return a >= 16'hFE00 && a < 16'hFEA0; endfunction

  function automatic bit blocked(input logic [15:0] a);
    return LOCK && lcd_en && ((is_vram(a) && ppu_mode == 2'd3) || (is_oam(a) && ppu_mode >= 2'd2));
  endfunction

  function automatic logic [7:0] cpu_model(input logic [15:0] a, input bit dma_on);
    if (is_vram(a) && !blocked(a)) return vram_m[a - 16'h8000];
    if (is_oam(a) && !blocked(a) && !dma_on) return oam_m[a - 16'hFE00];
    if (a == 16'hFF46) return dma_m;
    return 8'hFF;
  endfunction

  function automatic logic [7:0] ppu_model(input logic [15:0] a, input bit dma_on);
    if (is_vram(a)) return vram_m[a - 16'h8000];
    if (is_oam(a) && !dma_on) return oam_m[a - 16'hFE00];
    return 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    if (is_vram(a) && !blocked(a)) vram_m[a - 16'h8000] = d;
    if (is_oam(a) && !blocked(a) && !dma_active) oam_m[a - 16'hFE00] = d;
    if (a == 16'hFF46) dma_m = d;
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0; d = cpu_rdata;
  endtask

  task automatic ppu_read(input logic [15:0] a, output logic [7:0] d);
    ppu_addr = a; ppu_rd = 1'b1;
    @(negedge clk);
    ppu_rd = 1'b0; d = ppu_rdata;
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int k = 0;
    while (!(dma_src_rd && dma_src_addr == a) && k < 2000) begin @(negedge clk); k++; end
    chk("wait_dma_addr", {15'd0, k < 2000}, 16'd1);
  endtask

  task automatic count_active(output int c);
    c = 0;
    while (dma_active && c < 1000) begin @(negedge clk); c++; end
  endtask

  task automatic check_oam(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 160; i++) begin
      cpu_read(16'hFE00 + 16'(i), d);
      chk(tag, {8'h00, d}, {8'h00, oam_m[i]});
    end
  endtask

  initial begin
    logic [7:0]  d, e;
    logic [15:0] a;
    int cyc;
    rst = 1'b1; cpu_addr = 16'h0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h0;
    ppu_rd = 1'b0; ppu_addr = 16'h0; ppu_mode = 2'd0; lcd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_rdata", {8'h00, cpu_rdata}, 16'h00FF);
    chk("rst_ppu_rdata", {8'h00, ppu_rdata}, 16'h00FF);
    chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
    chk("rst_dma_src_rd", {15'd0, dma_src_rd}, 16'd0);
    chk("rst_dma_src_addr", dma_src_addr, 16'h0000);
    cpu_read(16'hFF46, d);
    chk("rst_dma_reg", {8'h00, d}, 16'h0000);

    // Fill both memories so every model entry is defined.
    for (int i = 0; i < 8192; i++) cpu_write(16'h8000 + 16'(i), 8'($urandom));
    for (int i = 0; i < 160; i++)  cpu_write(16'hFE00 + 16'(i), 8'($urandom));

    // Random CPU/PPU traffic under random mode and LCD enable.
    for (int i = 0; i < 400; i++) begin
      ppu_mode = 2'($urandom_range(0, 3));
      lcd_en   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: a = 16'h8000 + 16'($urandom_range(0, 8191));
        1: a = 16'hFE00 + 16'($urandom_range(0, 159));
        default: a = 16'($urandom);
      endcase
      if (a == 16'hFF46) a = 16'hFF47;
      case ($urandom_range(0, 2))
        0: cpu_write(a, 8'($urandom));
        1: begin e = cpu_model(a, 1'b0); cpu_read(a, d); chk("rand_cpu_read", {8'h00, d}, {8'h00, e}); end
        default: begin e = ppu_model(a, 1'b0); ppu_read(a, d); chk("rand_ppu_read", {8'h00, d}, {8'h00, e}); end
      endcase
    end
    ppu_mode = 2'd0; lcd_en = 1'b0;

    // Basic write then PPU fetch, hold, unmapped.
    cpu_write(16'h9800, 8'hAB);
    ppu_read(16'h9800, d);
    chk("ppu_fetch_9800", {8'h00, d}, 16'h00AB);
    ppu_addr = 16'h8000;
    @(negedge clk);
    chk("ppu_hold", {8'h00, ppu_rdata}, 16'h00AB);
    ppu_read(16'hC000, d);
    chk("ppu_unmapped", {8'h00, d}, 16'h00FF);

    // Mode lockout (or free access when the lockout is compiled out).
    lcd_en = 1'b1; ppu_mode = 2'd3;
    cpu_write(16'h8000, 8'h55);
    e = cpu_model(16'h8000, 1'b0); cpu_read(16'h8000, d);
    chk("draw_cpu_read", {8'h00, d}, {8'h00, e});
    ppu_mode = 2'd0;
    e = cpu_model(16'h8000, 1'b0); cpu_read(16'h8000, d);
    chk("hblank_cpu_read", {8'h00, d}, {8'h00, e});
    lcd_en = 1'b0;

    // Same-cycle CPU write and PPU read: PPU sees the old byte.
    cpu_write(16'h8010, 8'h22);
    cpu_addr = 16'h8010; cpu_wdata = 8'h11; cpu_wr = 1'b1; ppu_addr = 16'h8010; ppu_rd = 1'b1;
    vram_m[16'h0010] = 8'h11;
    @(negedge clk);
    cpu_wr = 1'b0; ppu_rd = 1'b0;
    chk("rbw_old", {8'h00, ppu_rdata}, 16'h0022);
    ppu_read(16'h8010, d);
    chk("rbw_new", {8'h00, d}, 16'h0011);

    // Full DMA from 0xC000 with the PPU in DRAW (DMA ignores mode).
    lcd_en = 1'b1; ppu_mode = 2'd3;
    cpu_write(16'hFF46, 8'hC0);
    chk("dma_rise", {15'd0, dma_active}, 16'd1);
    cyc = 0;
    while (dma_active && cyc < 1000) begin
      chk("dma_src_rd_phase", {15'd0, dma_src_rd}, {15'd0, cyc % 2 == 0});
      if (cyc % 2 == 0) chk("dma_src_addr", dma_src_addr, 16'hC000 + 16'(cyc / 2));
      @(negedge clk); cyc++;
    end
    chk("dma_len", 16'(cyc), 16'd320);
    chk("dma_idle_rd", {15'd0, dma_src_rd}, 16'd0);
    lcd_en = 1'b0; ppu_mode = 2'd0;
    for (int i = 0; i < 160; i++) oam_m[i] = 8'(i);
    check_oam("dma1_oam");
    cpu_read(16'hFF46, d);
    chk("dma_reg_read", {8'h00, d}, 16'h00C0);

    // CPU/PPU OAM access while DMA runs.
    cpu_write(16'hFF46, 8'hC1);
    cpu_read(16'hFE05, d);
    chk("dma_cpu_oam_read", {8'h00, d}, 16'h00FF);
    ppu_read(16'hFE05, d);
    chk("dma_ppu_oam_read", {8'h00, d}, 16'h00FF);
    cpu_write(16'hFE07, 8'h99);
    cpu_write(16'h8020, 8'h5A);
    count_active(cyc);
    chk("dma2_done", {15'd0, cyc < 1000}, 16'd1);
    for (int i = 0; i < 160; i++) oam_m[i] = 8'(i);
    check_oam("dma2_oam");
    cpu_read(16'h8020, d);
    chk("dma_vram_write", {8'h00, d}, 16'h005A);

    // Restart mid-transfer at idx 50.
    src_xor = 1'b1;
    cpu_write(16'hFF46, 8'hC2);
    wait_addr(16'hC232);
    cpu_write(16'hFF46, 8'hD0);
    count_active(cyc);
    chk("restart_len", 16'(cyc), 16'd320);
    for (int i = 0; i < 160; i++) oam_m[i] = 8'(i) ^ 8'hD0;
    check_oam("restart_oam");

    // Reset while DMA is at idx 80.
    cpu_write(16'hFF46, 8'hC3);
    wait_addr(16'hC350);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dma_m = 8'h00;
    chk("abort_active", {15'd0, dma_active}, 16'd0);
    chk("abort_src_rd", {15'd0, dma_src_rd}, 16'd0);
    chk("abort_src_addr", dma_src_addr, 16'h0000);
    chk("abort_cpu_rdata", {8'h00, cpu_rdata}, 16'h00FF);
    for (int i = 0; i < 80; i++) oam_m[i] = 8'(i) ^ 8'hC3;
    check_oam("abort_oam");
    cpu_read(16'hFF46, d);
    chk("abort_dma_reg", {8'h00, d}, 16'h0000);
    ppu_read(16'h9800, d);
    chk("vram_survives_rst", {8'h00, d}, 16'h00AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
